// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state set and constants; PARITY state exists only with UART_RX_PARITY_EN
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
`endif

    // Even parity: data bits plus parity bit must hold an even number of ones.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - single-bit multi-flop synchronizer, resets to the idle-high line level
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with single-entry output register and sticky error flags
// Optional macro UART_RX_PARITY_EN adds an even-parity bit, PARITY state and parity_error output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RsRx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 frame_error,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy
);

    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [TW-1:0]  HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    uart_state_e          state;
    logic [TW-1:0]        timer;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 rx;
    logic                 frame_done;
    logic                 stop_ok;
    logic                 commit;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RsRx),
        .q     (rx)
    );

    // frame_done/stop_ok carry the stop-bit verdict one cycle forward to the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            stop_ok    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state <= START;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_M1) begin
                        timer <= '0;
                        if (rx) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == FULL_M1) begin
                        timer   <= '0;
                        shift   <= {rx, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer == FULL_M1) begin
                        timer   <= '0;
                        par_bad <= parity_mismatch(shift, rx);
                        state   <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (timer == FULL_M1) begin
                        timer      <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        stop_ok    <= rx;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign commit = frame_done && stop_ok;

    // A commit beats a simultaneous rd_ack; setting a flag beats clearing it.
    always_ff @(posedge clk) begin
        if (reset) begin
            data         <= '0;
            data_ready   <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else begin
            if (rd_ack && !commit) begin
                data_ready   <= 1'b0;
                frame_error  <= 1'b0;
                overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_error <= 1'b0;
`endif
            end
            if (commit) begin
                data       <= shift;
                data_ready <= 1'b1;
                if (data_ready && !rd_ack) begin
                    overrun <= 1'b1;
                end
            end
            if (frame_done && !stop_ok) begin
                frame_error <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (frame_done && par_bad) begin
                parity_error <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (vector table, corner sequences, random frames vs model)
module tb_uart_rx;

    localparam int CLKS = 16;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // line fall -> synchronizer -> idle detect -> half bit -> data(+parity)+stop centres -> commit register
    localparam int LAT = SYNC + 1 + CLKS / 2 + (NBITS - 1) * CLKS + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RsRx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data;
    logic       data_ready;
    logic       frame_error;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    logic       par_flip = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    logic dr_prev = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CLKS), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .reset        (reset),
        .RsRx         (RsRx),
        .rd_ack       (rd_ack),
        .data         (data),
        .data_ready   (data_ready),
        .frame_error  (frame_error),
        .overrun      (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_ready && !dr_prev) rise_cyc = cyc;
        dr_prev = data_ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, (^b) ^ par_flip, b, 1'b0};
`else
        bits = {stop_bit, b, 1'b0};
`endif
        start_cyc = cyc;
        for (int i = 0; i < NBITS; i++) begin
            RsRx = bits[i];
            tick(CLKS);
        end
        RsRx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       ack;
        logic [7:0] e_data;
        logic       e_dr;
        logic       e_fe;
        logic       e_ov;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] m_data;
    logic       m_dr, m_fe, m_ov;
    logic       prev_dr;
    logic [9:0] pb;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

        tick(5);
        reset = 1'b0;
        chk("reset_data", data, 8'h00);
        chk("reset_data_ready", data_ready, 1'b0);
        chk("reset_frame_error", frame_error, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        chk("reset_busy", busy, 1'b0);

        prev_dr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rise_cyc = -1;
            send_frame(vecs[i].b, vecs[i].stop);
            tick(20);
            chk($sformatf("vec%0d_data", i), data, vecs[i].e_data);
            chk($sformatf("vec%0d_data_ready", i), data_ready, vecs[i].e_dr);
            chk($sformatf("vec%0d_frame_error", i), frame_error, vecs[i].e_fe);
            chk($sformatf("vec%0d_overrun", i), overrun, vecs[i].e_ov);
            chk($sformatf("vec%0d_busy", i), busy, 1'b0);
            if (vecs[i].stop && !prev_dr)
                chk($sformatf("vec%0d_latency", i), rise_cyc - start_cyc, LAT);
            if (vecs[i].ack) pulse_ack();
            prev_dr = vecs[i].ack ? 1'b0 : vecs[i].e_dr;
        end

        // short low glitch on an idle line
        RsRx = 1'b0;
        tick(4);
        RsRx = 1'b1;
        tick(2);
        chk("glitch_busy_during", busy, 1'b1);
        tick(30);
        chk("glitch_busy_after", busy, 1'b0);
        chk("glitch_data_ready", data_ready, 1'b0);
        chk("glitch_frame_error", frame_error, 1'b0);
        chk("glitch_overrun", overrun, 1'b0);
        chk("glitch_data", data, 8'h80);

        pulse_ack();
        chk("idle_ack_data_ready", data_ready, 1'b0);
        chk("idle_ack_data", data, 8'h80);

        // back-to-back frames without acknowledge
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        tick(20);
        chk("b2b_data", data, 8'h34);
        chk("b2b_data_ready", data_ready, 1'b1);
        chk("b2b_overrun", overrun, 1'b1);
        chk("b2b_frame_error", frame_error, 1'b0);
        pulse_ack();
        chk("b2b_ack_overrun", overrun, 1'b0);
        chk("b2b_ack_data_ready", data_ready, 1'b0);

        // rd_ack landing on the commit cycle
        send_frame(8'h12, 1'b1);
        tick(20);
        chk("collide_pre_data_ready", data_ready, 1'b1);
        fork
            send_frame(8'h34, 1'b1);
            begin
                tick(LAT - 1);
                rd_ack = 1'b1;
                tick(1);
                rd_ack = 1'b0;
            end
        join
        tick(20);
        chk("collide_data", data, 8'h34);
        chk("collide_data_ready", data_ready, 1'b1);
        chk("collide_overrun", overrun, 1'b0);

        // reset during data bit 4
        pb = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            RsRx = pb[i];
            tick(CLKS);
        end
        RsRx = pb[5];
        tick(4);
        reset = 1'b1;
        tick(1);
        chk("midreset_data", data, 8'h00);
        chk("midreset_data_ready", data_ready, 1'b0);
        chk("midreset_frame_error", frame_error, 1'b0);
        chk("midreset_overrun", overrun, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        reset = 1'b0;
        RsRx = 1'b1;
        tick(3 * CLKS);
        rise_cyc = -1;
        send_frame(8'hC0, 1'b1);
        tick(20);
        chk("after_reset_data", data, 8'hC0);
        chk("after_reset_data_ready", data_ready, 1'b1);
        chk("after_reset_frame_error", frame_error, 1'b0);
        chk("after_reset_latency", rise_cyc - start_cyc, LAT);

        // random frames against the behavioural model
        m_data = 8'hC0;
        m_dr = 1'b1;
        m_fe = 1'b0;
        m_ov = 1'b0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       s;
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(b, s);
            tick(20);
            if (s) begin
                m_ov = m_ov | m_dr;
                m_dr = 1'b1;
                m_data = b;
            end else begin
                m_fe = 1'b1;
            end
            chk($sformatf("rand%0d_data", n), data, m_data);
            chk($sformatf("rand%0d_data_ready", n), data_ready, m_dr);
            chk($sformatf("rand%0d_frame_error", n), frame_error, m_fe);
            chk($sformatf("rand%0d_overrun", n), overrun, m_ov);
            if (m_dr && ($urandom_range(0, 1) == 1)) begin
                pulse_ack();
                m_dr = 1'b0;
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
        end

`ifdef UART_RX_PARITY_EN
        pulse_ack();
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1);
        par_flip = 1'b0;
        tick(20);
        chk("parity_error_set", parity_error, 1'b1);
        chk("parity_data", data, 8'h01);
        chk("parity_data_ready", data_ready, 1'b1);
        chk("parity_frame_error", frame_error, 1'b0);
        pulse_ack();
        chk("parity_error_clear", parity_error, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, sets the number of clk cycles per serial bit (100 MHz / 115200 baud); it SHALL be at least 4.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of flip-flops in the rx input synchronizer; it SHALL be at least 2.
REQ-003 clk  input  1  is the single system clock; every register SHALL update on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 RsRx  input  1  is the asynchronous serial line; it idles high.
REQ-006 rd_ack  input  1  SHALL be a one-cycle pulse from the consumer that clears data_ready.
REQ-007 data  output  8  is the last received byte, held stable while data_ready is 1.
REQ-008 data_ready  output  1  SHALL be 1 when data holds an unread byte.
REQ-009 frame_error  output  1  is a sticky flag: stop bit sampled low.
REQ-010 overrun  output  1  is a sticky flag: a byte completed while data_ready was 1.
REQ-011 busy  output  1  SHALL be 1 whenever the state machine is not in IDLE.

Function
REQ-012 The receiver SHALL pass RsRx through SYNC_STAGES flip-flops before any use; all later references to rx mean the synchronized value.
REQ-013 The states SHALL be IDLE, START, DATA, STOP, plus PARITY when parity is enabled.
REQ-014 IDLE: on rx=0, go to START and clear the bit-timer.
REQ-015 START: at timer=CLKS_PER_BIT/2-1 (integer division), if rx=0 go to DATA and reset the timer; if rx=1, treat it as a glitch and return to IDLE with no flag change.
REQ-016 DATA: sample rx every CLKS_PER_BIT cycles, i.e. at the centre of each bit; shift the samples LSB-first into the shift register; after 8 samples go to STOP (or PARITY).
REQ-017 STOP: sample at the bit centre, then return to IDLE on the same cycle.
REQ-018 A stop sample of 1 SHALL load data from the shift register and set data_ready on the next clk edge.
REQ-019 A stop sample of 0 SHALL set frame_error; the byte is discarded and data is unchanged.
REQ-020 Byte commit latency: data_ready SHALL rise 1 clk after the stop-bit centre sample.
REQ-021 If a commit occurs while data_ready=1, the new byte SHALL overwrite data, overrun SHALL be set, and data_ready SHALL stay 1.
REQ-022 If rd_ack and a commit occur on the same cycle, the commit SHALL win: data_ready stays 1 and overrun is not set.
REQ-023 rd_ack while data_ready=0 SHALL be ignored.
REQ-024 frame_error and overrun SHALL clear only on reset, or on rd_ack when no commit occurs in that cycle.
REQ-025 The receiver SHALL accept back-to-back frames: a new start edge is detectable starting the cycle after the return to IDLE.
REQ-026 The bit-timer SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and SHALL never wrap within a bit.

Reset
REQ-027 Reset SHALL force the state to IDLE, the timer and bit count to 0, and the shift register and data to 8'h00.
REQ-028 Reset SHALL force data_ready, frame_error, overrun and busy to 0, and all synchronizer flip-flops to 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no commit; reception resumes at the next falling edge after reset deasserts.

Configuration
REQ-030 The macro UART_RX_PARITY_EN, when defined, SHALL add an even-parity bit after bit 7, sampled in state PARITY.
REQ-031 With UART_RX_PARITY_EN defined, a parity mismatch SHALL add a sticky output parity_error, set on a mismatch; the byte still commits if the stop bit is good; parity_error clears under the same rules as frame_error.
REQ-032 Without UART_RX_PARITY_EN, the PARITY state and the parity_error port SHALL not exist, and the frame SHALL be 10 bits.

Structure
REQ-033 The shared package uart_pkg SHALL hold the state enumeration, the default-baud constant and the data-width constant (8); the future uart_tx SHALL reuse this package.
REQ-034 The input synchronizer SHALL be one sub-module, sync_ff, with a width-1 parameterized depth; all other logic SHALL be in uart_rx.

Verification (CLKS_PER_BIT=16)
REQ-035 Send 0x55 with a good stop bit -> data=0x55, data_ready=1 exactly 1 clk after the stop centre, frame_error=0.
REQ-036 Drive a 4-cycle low glitch on an idle line -> returns to IDLE, data_ready stays 0, no flags set.
REQ-037 Send 0xA3 with the stop bit driven low -> frame_error=1, data_ready=0, data unchanged.
REQ-038 Send 0x12 then 0x34 back-to-back with no rd_ack -> data=0x34, overrun=1, data_ready=1.
REQ-039 Pulse rd_ack on the same cycle as the commit of 0x34 -> data_ready=1, overrun=0.
REQ-040 Assert reset during bit 4 of a frame -> all outputs 0 next cycle; the following frame 0xC0 is received correctly. With UART_RX_PARITY_EN, 0x01 sent with parity bit 0 -> parity_error=1, data=0x01.
